bcd_to_unsigned: RTL and testbench

Sequential reverse double-dabble converter: captures a 10-digit packed BCD word on a trigger pulse and produces its 40-bit unsigned binary value a fixed number of cycles later. It is the inverse of the team's binary-to-BCD converter. It sits between BCD-entry sources (keypad and UART digit buffers) and the vector coprocessor's binary operand registers. Conversion is a shift-right / subtract-3 FSM, one bit per shift cycle.

---
 rtl/bcd_to_unsigned.sv | 137 +++++++++++++
 tb/tb_bcd_to_unsigned.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/bcd_to_unsigned.sv
// Sequential reverse double-dabble: 10-digit packed BCD -> 40-bit unsigned binary, one bit per shift cycle.
// Optional nibble validation is compiled in when BCD_DIGIT_CHECK_EN is defined.
module bcd_to_unsigned #(
  parameter int DIGITS = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  trigger,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic                  idle,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bin,
  output logic                  invalid
);

  localparam int DATA_W = 4 * DIGITS;
  localparam int CNT_W  = 6;

  typedef enum logic [2:0] {
    S_IDLE  = 3'b001,
    S_SHIFT = 3'b010,
    S_SUB3  = 3'b100
  } state_t;

  state_t                state, state_nxt;
  logic [2*DATA_W-1:0]   work, work_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [DATA_W-1:0]     bin_nxt;
  logic                  done_nxt;
  logic [2*DATA_W-1:0]   work_shr;
  logic                  force_zero;

  // Undo the add-3 of double-dabble: any digit that reached 8+ after a shift gets 3 removed.
  function automatic logic [DATA_W-1:0] sub3_digits(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    logic [3:0]        nib;
    r = d;
    for (int i = 0; i < DIGITS; i++) begin
      nib = d[4*i +: 4];
      if (nib >= 4'd8) r[4*i +: 4] = nib - 4'd3;
    end
    return r;
  endfunction

`ifdef BCD_DIGIT_CHECK_EN
  function automatic logic any_bad_digit(input logic [DATA_W-1:0] d);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (d[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  logic flag, flag_nxt;
  logic invalid_nxt;
  assign force_zero = flag;
`else
  assign force_zero = 1'b0;
  assign invalid    = 1'b0;
`endif

  assign idle     = (state == S_IDLE);
  assign work_shr = work >> 1;

  always_comb begin
    state_nxt = state;
    work_nxt  = work;
    cnt_nxt   = cnt;
    bin_nxt   = bin;
    done_nxt  = 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
    flag_nxt    = flag;
    invalid_nxt = invalid;
`endif
    case (state)
      S_IDLE: begin
        if (trigger) begin
          work_nxt  = {bcd, {DATA_W{1'b0}}};
          cnt_nxt   = CNT_W'(1);
          state_nxt = S_SHIFT;
`ifdef BCD_DIGIT_CHECK_EN
          flag_nxt  = any_bad_digit(bcd);
`endif
        end
      end
      S_SHIFT: begin
        work_nxt = work_shr;
        if (cnt == CNT_W'(DATA_W)) begin
          bin_nxt   = force_zero ? '0 : work_shr[DATA_W-1:0];
          done_nxt  = 1'b1;
          state_nxt = S_IDLE;
`ifdef BCD_DIGIT_CHECK_EN
          invalid_nxt = flag;
`endif
        end else begin
          cnt_nxt   = cnt + CNT_W'(1);
          state_nxt = S_SUB3;
        end
      end
      S_SUB3: begin
        work_nxt  = {sub3_digits(work[2*DATA_W-1:DATA_W]), work[DATA_W-1:0]};
        state_nxt = S_SHIFT;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      work  <= '0;
      cnt   <= '0;
      bin   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      work  <= work_nxt;
      cnt   <= cnt_nxt;
      bin   <= bin_nxt;
      done  <= done_nxt;
    end
  end

`ifdef BCD_DIGIT_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      flag    <= 1'b0;
      invalid <= 1'b0;
    end else begin
      flag    <= flag_nxt;
      invalid <= (state == S_SHIFT && cnt == CNT_W'(DATA_W)) ? invalid_nxt : 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_bcd_to_unsigned.sv
// Directed bench for bcd_to_unsigned: latency, known conversions, back-to-back, reset abort, digit check.
module tb_bcd_to_unsigned;

  logic        clk = 1'b0;
  logic        reset;
  logic        trigger;
  logic [39:0] bcd;
  logic        idle;
  logic        done;
  logic [39:0] bin;
  logic        invalid;

  int checks   = 0;
  int failures = 0;

  bcd_to_unsigned #(.DIGITS(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .trigger (trigger),
    .bcd     (bcd),
    .idle    (idle),
    .done    (done),
    .bin     (bin),
    .invalid (invalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance edge by edge (sampling 1 unit after each) until done, bounded.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (done !== 1'b1 && n < 300);
  endtask

  task automatic run_conv(input string tag, input logic [39:0] v, input logic [39:0] exp);
    int n;
    chk({tag, "_idle_before"}, 64'(idle), 64'd1);
    bcd     = v;
    trigger = 1'b1;
    @(posedge clk);
    #1;
    trigger = 1'b0;
    bcd     = 40'h33_3333_3333;
    wait_done(n);
    chk({tag, "_latency"}, 64'(n), 64'd79);
    chk({tag, "_bin"}, 64'(bin), 64'(exp));
    chk({tag, "_invalid"}, 64'(invalid), 64'd0);
    chk({tag, "_idle_at_done"}, 64'(idle), 64'd1);
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    chk({tag, "_bin_hold"}, 64'(bin), 64'(exp));
  endtask

  initial begin
    int n;
    int t;
    int seen_done;
    reset   = 1'b1;
    trigger = 1'b0;
    bcd     = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_bin", 64'(bin), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_invalid", 64'(invalid), 64'd0);

    run_conv("c255", 40'h00_0000_0255, 40'h00_0000_00FF);
    run_conv("c9s", 40'h99_9999_9999, 40'h02_540B_E3FF);
    run_conv("c0", 40'h00_0000_0000, 40'h00_0000_0000);
    run_conv("c10k", 40'h00_0001_0000, 40'h00_0000_2710);
    run_conv("c1234567890", 40'h12_3456_7890, 40'h00_4996_02D2);

    // Non-decimal nibble
    bcd     = 40'h00_0000_00A1;
    trigger = 1'b1;
    @(posedge clk);
    #1;
    trigger = 1'b0;
    wait_done(n);
    chk("bad_latency", 64'(n), 64'd79);
`ifdef BCD_DIGIT_CHECK_EN
    chk("bad_invalid", 64'(invalid), 64'd1);
    chk("bad_bin", 64'(bin), 64'd0);
`else
    chk("bad_invalid", 64'(invalid), 64'd0);
`endif
    @(posedge clk);
    #1;
    chk("bad_done_pulse", 64'(done), 64'd0);
    chk("bad_invalid_clear", 64'(invalid), 64'd0);

    // Back-to-back with trigger held; bcd changes mid-conversion must not matter
    bcd     = 40'h00_0000_0012;
    trigger = 1'b1;
    @(posedge clk);
    #1;
    bcd = 40'h00_0000_0055;
    repeat (39) @(posedge clk);
    #1;
    bcd = 40'h00_0000_0034;
    wait_done(n);
    chk("b2b_first_latency", 64'(39 + n), 64'd79);
    chk("b2b_first_bin", 64'(bin), 64'h0C);
    @(posedge clk);
    #1;
    chk("b2b_done_pulse", 64'(done), 64'd0);
    chk("b2b_recaptured", 64'(idle), 64'd0);
    bcd = 40'h00_0000_0077;
    repeat (20) @(posedge clk);
    #1;
    trigger = 1'b0;
    wait_done(n);
    chk("b2b_period", 64'(1 + 20 + n), 64'd80);
    chk("b2b_second_bin", 64'(bin), 64'h22);
    @(posedge clk);
    #1;

    // Reset 30 cycles into a conversion aborts it
    run_conv("pre_abort", 40'h00_0001_0000, 40'h00_0000_2710);
    bcd     = 40'h00_0000_0255;
    trigger = 1'b1;
    @(posedge clk);
    #1;
    trigger = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    reset   = 1'b1;
    trigger = 1'b1;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    trigger = 1'b0;
    chk("abort_idle", 64'(idle), 64'd1);
    chk("abort_bin", 64'(bin), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    seen_done = 0;
    for (t = 0; t < 100; t++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) seen_done = 1;
    end
    chk("abort_no_done", 64'(seen_done), 64'd0);
    chk("abort_still_idle", 64'(idle), 64'd1);
    run_conv("post_abort", 40'h00_0000_0255, 40'h00_0000_00FF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
